// File: rtl/data_mem_bridge_if.sv
// Word-addressed request/acknowledge data bus between the bridge and memory.
interface data_mem_bridge_if;
  logic        req;    // request, held until ack
  logic        we;     // 1 = write, 0 = read
  logic [29:0] baddr;  // word address
  logic [31:0] wdata;  // lane-replicated write data
  logic [3:0]  be;     // byte enables, bit n = lane n
  logic        ack;    // request completes this cycle
  logic [31:0] rdata;  // read data, valid with ack on reads

  modport master (
    output req, we, baddr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, baddr, wdata, be,
    output ack, rdata
  );
endinterface

// File: rtl/data_mem_bridge.sv
// Multi-cycle bridge from the RV32 core's combinational load/store port to a
// word-addressed req/ack bus: lane steering, load right-alignment, core stall,
// misaligned/invalid store and bus timeout faults.
module data_mem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memsize,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_fault,
  data_mem_bridge_if.master bus
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUS  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [29:0]      baddr_q, baddr_d;
  logic [31:0]      bdata_q, bdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       off_q, off_d;

  logic [CNT_W:0]   cnt_inc;
  logic             store_bad;
  logic [3:0]       store_be;
  logic [31:0]      store_data;

  // Store lane steering and validity check for the current core request.
  always_comb begin
    store_bad  = 1'b0;
    store_be   = 4'b0000;
    store_data = i_wdata;
    case (i_memsize)
      2'b01: begin
        store_be   = 4'(4'b0001 << i_addr[1:0]);
        store_data = {4{i_wdata[7:0]}};
      end
      2'b10: begin
        store_be   = i_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{i_wdata[15:0]}};
        store_bad  = i_addr[0];
      end
      2'b11: begin
        store_be   = 4'b1111;
        store_data = i_wdata;
        store_bad  = (i_addr[1:0] != 2'b00);
      end
      default: begin
        store_bad  = 1'b1;
      end
    endcase
  end

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // Next-state and next-output logic; registered outputs hold by default.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    baddr_d = baddr_q;
    bdata_d = bdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    fault_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_write) begin
          if (store_bad) begin
            state_d = S_DONE;
            fault_d = 1'b1;
          end else begin
            state_d = S_BUS;
            req_d   = 1'b1;
            we_d    = 1'b1;
            baddr_d = i_addr[31:2];
            bdata_d = store_data;
            be_d    = store_be;
            off_d   = i_addr[1:0];
            cnt_d   = '0;
          end
        end else if (i_load) begin
          state_d = S_BUS;
          req_d   = 1'b1;
          we_d    = 1'b0;
          baddr_d = i_addr[31:2];
          be_d    = 4'b1111;
          off_d   = i_addr[1:0];
          cnt_d   = '0;
        end
      end
      S_BUS: begin
        if (bus.ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d = bus.rdata >> {off_q, 3'b000};
          end
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (cnt_inc == (CNT_W+1)'(TIMEOUT)) begin
            req_d   = 1'b0;
            rdata_d = '0;
            fault_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      baddr_q <= '0;
      bdata_q <= '0;
      be_q    <= 4'b0000;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      baddr_q <= baddr_d;
      bdata_q <= bdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
    end
  end

  // Stall covers the request cycle in IDLE and every bus cycle.
  assign o_stall = ((state_q == S_IDLE) && (i_load || i_write)) || (state_q == S_BUS);

  assign o_rdata   = rdata_q;
  assign o_fault   = fault_q;
  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.baddr = baddr_q;
  assign bus.wdata = bdata_q;
  assign bus.be    = be_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: directed scenarios plus random
// loads/stores against a transaction-level expectation model.
module tb_data_mem_bridge;

  localparam int unsigned TO = 4;

  logic        i_clk;
  logic        i_rst;
  logic        i_load;
  logic        i_write;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [1:0]  i_memsize;
  logic [31:0] o_rdata;
  logic        o_stall;
  logic        o_fault;

  data_mem_bridge_if bus_if ();

  data_mem_bridge #(.TIMEOUT(TO)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (i_load),
    .i_write   (i_write),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_memsize (i_memsize),
    .o_rdata   (o_rdata),
    .o_stall   (o_stall),
    .o_fault   (o_fault),
    .bus       (bus_if.master)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rdata;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one core instruction starting at a negedge and checks the whole
  // access against expectations derived from the request and bus behaviour.
  task automatic run_access(input logic ld, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size,
                            input int wait_n, input logic [31:0] bus_data,
                            input logic late_ack);
    int          off;
    logic        invalid;
    logic        tmo;
    logic        done;
    int          stall_n;
    int          req_n;
    int          cyc;
    int          exp_stall;
    int          exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_bdata;

    off       = int'(addr % 4);
    i_load    = ld;
    i_write   = wr;
    i_addr    = addr;
    i_wdata   = wdata;
    i_memsize = size;

    if (!ld && !wr) begin
      bus_if.ack = 1'b1;
      #1;
      check("nomem_stall", 32'(o_stall), 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      bus_if.ack = 1'b0;
      check("nomem_req", 32'(bus_if.req), 32'd0);
      check("nomem_rdata", o_rdata, exp_rdata);
      return;
    end

    invalid = wr && ((size == 2'd0) || (size == 2'd2 && off % 2 == 1) ||
                     (size == 2'd3 && off != 0));
    tmo     = !invalid && (wait_n >= int'(TO));

    exp_be    = 4'b1111;
    exp_bdata = wdata;
    if (wr && size == 2'd1) begin
      exp_be    = 4'(1 << off);
      exp_bdata = 32'(wdata[7:0]) * 32'h0101_0101;
    end else if (wr && size == 2'd2) begin
      exp_be    = (off >= 2) ? 4'b1100 : 4'b0011;
      exp_bdata = 32'(wdata[15:0]) * 32'h0001_0001;
    end

    if (invalid) begin
      exp_stall = 1;
      exp_req   = 0;
    end else if (tmo) begin
      exp_stall = 1 + int'(TO);
      exp_req   = int'(TO);
    end else begin
      exp_stall = 2 + wait_n;
      exp_req   = 1 + wait_n;
    end

    stall_n = 0;
    req_n   = 0;
    cyc     = 0;
    done    = 1'b0;
    #1;
    check("c0_req", 32'(bus_if.req), 32'd0);
    while (!done && cyc < 64) begin
      if (o_stall) stall_n++;
      else done = 1'b1;
      if (bus_if.req) begin
        check("bus_we", 32'(bus_if.we), 32'(wr));
        check("bus_baddr", 32'(bus_if.baddr), addr / 4);
        check("bus_be", 32'(bus_if.be), 32'(exp_be));
        if (wr) check("bus_wdata", bus_if.wdata, exp_bdata);
        bus_if.ack   = (req_n == wait_n);
        bus_if.rdata = (req_n == wait_n) ? bus_data : $urandom;
        req_n++;
      end else begin
        bus_if.ack = 1'b0;
      end
      if (!done) begin
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        cyc++;
      end
    end
    if (!done) check("done_bound", 32'(cyc), 32'd0);

    if (tmo) exp_rdata = 32'd0;
    else if (!invalid && !wr) exp_rdata = bus_data >> (8 * off);

    check("stall_cycles", 32'(stall_n), 32'(exp_stall));
    check("req_cycles", 32'(req_n), 32'(exp_req));
    check("done_fault", 32'(o_fault), 32'(invalid || tmo));
    check("done_req", 32'(bus_if.req), 32'd0);
    check("done_rdata", o_rdata, exp_rdata);

    i_load     = 1'b0;
    i_write    = 1'b0;
    bus_if.ack = late_ack;
    bus_if.rdata = 32'hFFFF_FFFF;
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    bus_if.ack = 1'b0;
    check("post_fault", 32'(o_fault), 32'd0);
    check("post_stall", 32'(o_stall), 32'd0);
    check("post_req", 32'(bus_if.req), 32'd0);
    check("post_rdata", o_rdata, exp_rdata);
    @(negedge i_clk);
  endtask

  initial begin
    logic [31:0] a;
    logic        ld;
    logic        wr;
    int          kind;

    i_rst        = 1'b1;
    i_load       = 1'b0;
    i_write      = 1'b0;
    i_addr       = '0;
    i_wdata      = '0;
    i_memsize    = 2'b00;
    bus_if.ack   = 1'b0;
    bus_if.rdata = '0;
    exp_rdata    = '0;

    // Reset values, and stall following a request while still in reset.
    repeat (2) @(negedge i_clk);
    check("rst_req", 32'(bus_if.req), 32'd0);
    check("rst_we", 32'(bus_if.we), 32'd0);
    check("rst_be", 32'(bus_if.be), 32'd0);
    check("rst_baddr", 32'(bus_if.baddr), 32'd0);
    check("rst_wdata", bus_if.wdata, 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_stall_idle", 32'(o_stall), 32'd0);
    i_load = 1'b1;
    #1;
    check("rst_stall_req", 32'(o_stall), 32'd1);
    i_load = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Directed scenarios.
    run_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'b00, 0, 32'hDEAD_BEEF, 1'b0);
    run_access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 2'b00, 3, 32'hAABB_CCDD, 1'b0);
    run_access(1'b0, 1'b1, 32'h0000_0202, 32'h0000_005A, 2'b01, 0, 32'h0, 1'b0);
    run_access(1'b0, 1'b1, 32'h0000_0202, 32'h0000_1234, 2'b10, 1, 32'h0, 1'b0);
    run_access(1'b0, 1'b1, 32'h0000_0201, 32'h1111_2222, 2'b11, 0, 32'h0, 1'b0);
    run_access(1'b0, 1'b1, 32'h0000_0200, 32'h1111_2222, 2'b00, 0, 32'h0, 1'b0);
    run_access(1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 2'b11, 2, 32'h0, 1'b0);
    run_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 2'b00, 0, 32'h1234_5678, 1'b0);
    run_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 2'b00, 99, 32'h5555_5555, 1'b1);
    run_access(1'b0, 1'b0, 32'h0000_0600, 32'h0, 2'b00, 0, 32'h0, 1'b0);

    // Reset asserted in the second bus cycle abandons the transaction.
    run_access(1'b1, 1'b0, 32'h0000_0704, 32'h0, 2'b00, 0, 32'h0BAD_0BAD, 1'b0);
    i_load = 1'b1;
    i_addr = 32'h0000_0800;
    @(negedge i_clk);
    check("mid_bus1_req", 32'(bus_if.req), 32'd1);
    @(negedge i_clk);
    check("mid_bus2_req", 32'(bus_if.req), 32'd1);
    i_rst = 1'b1;
    #1;
    check("arst_req", 32'(bus_if.req), 32'd0);
    check("arst_be", 32'(bus_if.be), 32'd0);
    check("arst_baddr", 32'(bus_if.baddr), 32'd0);
    check("arst_rdata", o_rdata, 32'd0);
    check("arst_fault", 32'(o_fault), 32'd0);
    check("arst_stall", 32'(o_stall), 32'd1);
    exp_rdata = 32'd0;
    @(negedge i_clk);
    check("arst_hold_fault", 32'(o_fault), 32'd0);
    i_rst  = 1'b0;
    i_load = 1'b0;
    run_access(1'b0, 1'b1, 32'h0000_0903, 32'h0000_00C3, 2'b01, 1, 32'h0, 1'b0);

    // Random loads, stores and idle instructions.
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 7));
      ld   = (kind >= 1 && kind <= 4) || kind == 7;
      wr   = (kind >= 5);
      a    = $urandom;
      run_access(ld, wr, a, $urandom, 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 5)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_checks, 0);
    $fatal(1);
  end

endmodule
